mem_arbiter: RTL
================

# mem_arbiter

Shares the single memory port of the rv32 core between instruction fetch and the load/store unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The block allows one transaction in flight at a time. Data accesses have priority, and a starvation counter guarantees fetch progress. It sits between the fetch/memory pipeline stages and the memory, and complements the hazard bubble logic that stalls decode while a load/store is in flight.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- STARVE_MAX, 4, maximum number of consecutive data grants while fetch is pending (≥1)

- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- ireq_valid / ireq_ready  in / out  1  fetch request handshake
- ireq_addr  in  ADDR_WIDTH  fetch address
- irsp_valid / irsp_ready  out / in  1  fetch response handshake
- irsp_data  out  DATA_WIDTH  fetched instruction
- dreq_valid / dreq_ready  in / out  1  data request handshake
- dreq_addr  in  ADDR_WIDTH; dreq_we  in  1; dreq_wdata  in  DATA_WIDTH; dreq_strb  in  DATA_WIDTH/8
- drsp_valid / drsp_ready  out / in  1  data response handshake
- drsp_data  out  DATA_WIDTH  load data (undefined for stores)
- mreq_valid / mreq_ready  out / in  1  memory request handshake
- mreq_addr, mreq_we, mreq_wdata, mreq_strb  out  memory request payload, registered
- mrsp_valid / mrsp_ready  in / out  1  memory response handshake
- mrsp_data  in  DATA_WIDTH  memory read data
- busy  out  1  high whenever state ≠ IDLE
- err  out  1  sticky flag: mrsp_valid seen outside RESP

## Operation
- FSM states: IDLE, REQ, RESP. The owner register (I/D) records the granted requester.
- Arbitration in IDLE:
  - Data wins when dreq_valid is high, unless starve_cnt == STARVE_MAX and ireq_valid is high; in that case fetch wins.
  - Only the winner sees its ready = 1. The loser's ready = 0.
  - ireq_ready and dreq_ready are 0 in every state other than IDLE.
- On winner handshake in IDLE:
  - Latch the payload into the mreq_* registers. Fetch requests force we = 0 and strb = all-ones.
  - Set owner and go to REQ.
- starve_cnt update, applied on each grant:
  - Data granted while ireq_valid is high: increment, saturating at STARVE_MAX.
  - Fetch granted: clear to 0.
  - Data granted while ireq_valid is low: clear to 0.
- REQ:
  - mreq_valid = 1 with a stable payload until mreq_ready is high.
  - On handshake go to RESP.
- RESP:
  - Owner's rsp_valid = mrsp_valid; owner's rsp_data = mrsp_data (combinational pass-through).
  - mrsp_ready = owner's rsp_ready.
  - Non-owner's rsp_valid = 0.
  - On mrsp handshake go to IDLE.
- Every request, stores included, receives exactly one memory response. Stores complete only on that response.
- Responses arriving outside RESP:
  - mrsp_ready = 0 outside RESP.
  - mrsp_valid outside RESP sets err. Only reset clears err.
- Simultaneous ireq_valid and dreq_valid in IDLE resolve per the starvation rule. The losing request stays pending and its payload must be held by the requester.

## Timing
- Reset (async assert, sync-released use):
  - state = IDLE, owner = D, starve_cnt = 0.
  - All *_valid and *_ready outputs = 0, except the ready computed combinationally in IDLE.
  - busy = 0, err = 0, mreq_* payload = 0.
- Reset mid-transaction aborts immediately. The memory shares resetn, so no stale response is expected.
- Cycle 0: request handshake in IDLE.
- Cycle 1: mreq_valid = 1. If mreq_ready = 1 in that cycle, state is RESP from cycle 2.
- The response handshake in cycle N returns the FSM to IDLE in cycle N+1. A new request can be accepted in cycle N+1.
- Minimum: 3 cycles per transaction. Request-to-response latency is 2 cycles plus memory latency.
- Back-pressure: mreq_ready low holds REQ indefinitely. A response-side ready low holds RESP indefinitely. No timeout.

## Test plan
- Single fetch to 0x100, memory ready immediately, returns 0x00000013 one cycle later → mreq_valid in cycle 1, irsp_valid with data 0x13 in cycle 3, busy is 1 for cycles 1-3.
- Simultaneous ireq (0x200) and dreq load (0x8000) → data is granted first. Fetch is granted in the IDLE cycle after drsp completes. irsp_valid is never asserted during the data transaction.
- Continuous dreq_valid with ireq_valid held, STARVE_MAX = 4 → exactly 4 data grants, then 1 fetch grant, then the counter restarts. The pattern repeats D,D,D,D,I.
- Store 0xDEADBEEF, strb 0x3 at 0x40, mreq_ready low for 5 cycles → payload is stable for all 5 cycles. drsp_valid is asserted only after the memory ack. dreq_ready stays 0 throughout.
- drsp_ready held low for 3 cycles while mrsp_valid is high → mrsp_ready = 0 and the FSM stays in RESP. It exits on the cycle after drsp_ready rises.
- mrsp_valid pulsed while IDLE → err = 1 and stays 1. Assert resetn = 0 during REQ → state returns to IDLE immediately, and all outputs return to their reset values, err included.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the
// load/store unit. One transaction in flight; data has priority, bounded by
// a starvation counter that forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  // fetch request / response
  input  logic                    ireq_valid,
  output logic                    ireq_ready,
  input  logic [ADDR_WIDTH-1:0]   ireq_addr,
  output logic                    irsp_valid,
  input  logic                    irsp_ready,
  output logic [DATA_WIDTH-1:0]   irsp_data,
  // data request / response
  input  logic                    dreq_valid,
  output logic                    dreq_ready,
  input  logic [ADDR_WIDTH-1:0]   dreq_addr,
  input  logic                    dreq_we,
  input  logic [DATA_WIDTH-1:0]   dreq_wdata,
  input  logic [DATA_WIDTH/8-1:0] dreq_strb,
  output logic                    drsp_valid,
  input  logic                    drsp_ready,
  output logic [DATA_WIDTH-1:0]   drsp_data,
  // memory request / response
  output logic                    mreq_valid,
  input  logic                    mreq_ready,
  output logic [ADDR_WIDTH-1:0]   mreq_addr,
  output logic                    mreq_we,
  output logic [DATA_WIDTH-1:0]   mreq_wdata,
  output logic [DATA_WIDTH/8-1:0] mreq_strb,
  input  logic                    mrsp_valid,
  output logic                    mrsp_ready,
  input  logic [DATA_WIDTH-1:0]   mrsp_data,
  // status
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } mreq_t;

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  logic [CNT_WIDTH-1:0] starve_q, starve_d;
  mreq_t                req_q, req_d;
  logic                 err_q, err_d;

  logic starved;
  logic fetch_wins;
  logic data_wins;

  // Arbitration: data first unless fetch has waited through STARVE_MAX data grants
  always_comb begin
    starved    = (starve_q == CNT_WIDTH'(STARVE_MAX));
    fetch_wins = ireq_valid && (!dreq_valid || starved);
    data_wins  = dreq_valid && !fetch_wins;
  end

  // Next-state, payload capture, starvation bookkeeping and handshake outputs
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    req_d      = req_q;
    err_d      = err_q | (mrsp_valid && (state_q != ST_RESP));
    ireq_ready = 1'b0;
    dreq_ready = 1'b0;
    irsp_valid = 1'b0;
    drsp_valid = 1'b0;
    mrsp_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ireq_ready = fetch_wins;
        dreq_ready = data_wins;
        if (fetch_wins) begin
          req_d.addr  = ireq_addr;
          req_d.we    = 1'b0;
          req_d.wdata = '0;
          req_d.strb  = '1;
          owner_d     = OWN_I;
          starve_d    = '0;
          state_d     = ST_REQ;
        end else if (data_wins) begin
          req_d.addr  = dreq_addr;
          req_d.we    = dreq_we;
          req_d.wdata = dreq_wdata;
          req_d.strb  = dreq_strb;
          owner_d     = OWN_D;
          if (!ireq_valid) begin
            starve_d = '0;
          end else if (!starved) begin
            starve_d = starve_q + CNT_WIDTH'(1);
          end
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mreq_ready) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (owner_q == OWN_I) begin
          irsp_valid = mrsp_valid;
          mrsp_ready = irsp_ready;
        end else begin
          drsp_valid = mrsp_valid;
          mrsp_ready = drsp_ready;
        end
        if (mrsp_valid && mrsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, owner, counter, payload and sticky error registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_D;
      starve_q <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      req_q    <= req_d;
      err_q    <= err_d;
    end
  end

  // Registered request payload and status decoded from the state register
  assign mreq_valid = (state_q == ST_REQ);
  assign mreq_addr  = req_q.addr;
  assign mreq_we    = req_q.we;
  assign mreq_wdata = req_q.wdata;
  assign mreq_strb  = req_q.strb;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

  // Response data passes straight through; valid qualifies it for the owner only
  assign irsp_data = mrsp_data;
  assign drsp_data = mrsp_data;

endmodule
